// File: rtl/scan_pkg.sv
// Shared types and constants for the decoder scan sequencer.
// Used by the interface, the dwell counter and the top level.
package scan_pkg;

    localparam int ADDR_W      = 4;
    localparam int NUM_OUTPUTS = 16;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Next address in sweep order, wrapping modulo 16
    function automatic logic [ADDR_W-1:0] step_addr(
        input logic [ADDR_W-1:0] a,
        input logic              down
    );
        return down ? a - 1'b1 : a + 1'b1;
    endfunction

endpackage

// File: rtl/decoder_scan_sequencer_if.sv
// Control/status bundle between the sweep controller and the sequencer.
// SCAN_CONTINUOUS_EN adds the repeat_req request line.
interface decoder_scan_sequencer_if;
    import scan_pkg::*;

    logic              start;
    logic              stop;
    logic              dir;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
`ifdef SCAN_CONTINUOUS_EN
    logic              repeat_req;
`endif
    logic              enable;
    logic              A3;
    logic              A2;
    logic              A1;
    logic              A0;
    logic              busy;
    logic              done;

`ifdef SCAN_CONTINUOUS_EN
    modport master (
        output start, stop, dir, first_addr, last_addr, repeat_req,
        input  enable, A3, A2, A1, A0, busy, done
    );
    modport slave (
        input  start, stop, dir, first_addr, last_addr, repeat_req,
        output enable, A3, A2, A1, A0, busy, done
    );
`else
    modport master (
        output start, stop, dir, first_addr, last_addr,
        input  enable, A3, A2, A1, A0, busy, done
    );
    modport slave (
        input  start, stop, dir, first_addr, last_addr,
        output enable, A3, A2, A1, A0, busy, done
    );
`endif

endinterface

// File: rtl/decoder_scan_sequencer_dwell_counter.sv
// Per-address hold counter: counts 0..DWELL_CYCLES-1 and wraps.
// tc flags the last cycle of the current address.
module dwell_counter
    import scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = (cnt == LAST);

    // Count while enabled, wrap at terminal count, clear on request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Address sweep generator feeding a 4-to-16 enable decoder.
// Optional SCAN_CONTINUOUS_EN: repeat_req reloads the sweep without a gap.
module decoder_scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    decoder_scan_sequencer_if.slave  bus
);

    scan_state_t       state;
    scan_state_t       state_n;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_n;
    logic [ADDR_W-1:0] first_q;
    logic [ADDR_W-1:0] last_q;
    logic              dir_q;
    logic              load;
    logic              done_n;
    logic              run_n;
    logic              enable_q;
    logic              busy_q;
    logic              done_q;
    logic              tc;
    logic              cnt_clr;
    logic              cnt_en;
    logic              reload;

    assign cnt_en  = (state == RUN);
    assign cnt_clr = (state != RUN);
    assign run_n   = (state_n == RUN);

`ifdef SCAN_CONTINUOUS_EN
    assign reload = bus.repeat_req;
`else
    assign reload = 1'b0;
`endif

    dwell_counter #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (tc)
    );

    // Next-state, next-address and done-pulse decode
    always_comb begin
        state_n = state;
        addr_n  = addr;
        load    = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                addr_n = '0;
                if (bus.start && !bus.stop) begin
                    load    = 1'b1;
                    addr_n  = bus.first_addr;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_n = IDLE;
                    addr_n  = '0;
                end else if (tc) begin
                    if (addr != last_q) begin
                        addr_n = step_addr(addr, dir_q);
                    end else if (reload) begin
                        addr_n = first_q;
                        done_n = 1'b1;
                    end else begin
                        state_n = DONE;
                        addr_n  = '0;
                        done_n  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                addr_n  = '0;
            end
            default: begin
                state_n = IDLE;
                addr_n  = '0;
            end
        endcase
    end

    // State, sweep parameters and registered decoder outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= '0;
            first_q  <= '0;
            last_q   <= '0;
            dir_q    <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            addr     <= addr_n;
            enable_q <= run_n;
            busy_q   <= run_n;
            done_q   <= done_n;
            if (load) begin
                first_q <= bus.first_addr;
                last_q  <= bus.last_addr;
                dir_q   <= bus.dir;
            end
        end
    end

    assign bus.enable = enable_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.A3     = addr[3];
    assign bus.A2     = addr[2];
    assign bus.A1     = addr[1];
    assign bus.A0     = addr[0];

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Self-checking bench for decoder_scan_sequencer.
// Define SCAN_CONTINUOUS_EN to also exercise the repeat feature.
module tb_decoder_scan_sequencer;

    localparam int DWELL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    decoder_scan_sequencer_if bus();

    decoder_scan_sequencer #(
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {enable, busy, done, A3..A0}
    logic [6:0] obs;
    assign obs = {bus.enable, bus.busy, bus.done,
                  bus.A3, bus.A2, bus.A1, bus.A0};

`ifdef SCAN_CONTINUOUS_EN
    decoder_scan_sequencer_if bus1();
    logic [6:0] obs1;

    decoder_scan_sequencer #(
        .DWELL_CYCLES (1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    assign obs1 = {bus1.enable, bus1.busy, bus1.done,
                   bus1.A3, bus1.A2, bus1.A1, bus1.A0};
`endif

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL reset_hold got=%b exp=%b", obs, 7'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL reset_release got=%b exp=%b", obs, 7'b0);
        end
    endtask

    // Runs one sweep from IDLE; ends at the idle cycle after DONE.
    task automatic test_sweep(input logic [3:0] f, input logic [3:0] l,
                              input logic d, input bit jitter,
                              input bit hold);
        logic [3:0] diff;
        logic [3:0] seq[$];
        logic [6:0] exp;
        int         n;
        diff = d ? f - l : l - f;
        n = int'(diff) + 1;
        for (int i = 0; i < n; i++)
            seq.push_back(d ? f - 4'(i) : f + 4'(i));
        bus.first_addr = f;
        bus.last_addr  = l;
        bus.dir        = d;
        bus.start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < n * DWELL; c++) begin
            exp = {3'b110, seq[c / DWELL]};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL sweep f=%0d l=%0d d=%0d cyc=%0d got=%b exp=%b",
                         f, l, d, c, obs, exp);
            end
            if (jitter) begin
                bus.first_addr = 4'($urandom_range(0, 15));
                bus.last_addr  = 4'($urandom_range(0, 15));
                bus.dir        = 1'($urandom_range(0, 1));
                bus.start      = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        bus.start = hold;
        tests++;
        if (obs !== 7'b0010000) begin
            fails++;
            $display("FAIL sweep_done f=%0d l=%0d d=%0d got=%b exp=%b",
                     f, l, d, obs, 7'b0010000);
        end
        @(negedge clk);
        tests++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL sweep_idle f=%0d l=%0d d=%0d got=%b exp=%b",
                     f, l, d, obs, 7'b0);
        end
        if (hold) begin
            bus.start = 1'b0;
            @(negedge clk);
            tests++;
            if (obs !== 7'b0) begin
                fails++;
                $display("FAIL start_queued got=%b exp=%b", obs, 7'b0);
            end
        end
    endtask

    task automatic test_back_to_back();
        test_sweep(4'd9, 4'd11, 1'b0, 1'b0, 1'b0);
        test_sweep(4'd1, 4'd15, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stop();
        bus.first_addr = 4'd0;
        bus.last_addr  = 4'd15;
        bus.dir        = 1'b0;
        bus.start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        tests++;
        if (obs !== 7'b1100010) begin
            fails++;
            $display("FAIL stop_pre got=%b exp=%b", obs, 7'b1100010);
        end
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        for (int c = 0; c < 80; c++) begin
            tests++;
            if (obs !== 7'b0) begin
                fails++;
                $display("FAIL stop_idle cyc=%0d got=%b exp=%b",
                         c, obs, 7'b0);
            end
            @(negedge clk);
        end
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (obs !== 7'b0) begin
                fails++;
                $display("FAIL start_stop cyc=%0d got=%b exp=%b",
                         c, obs, 7'b0);
            end
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.first_addr = 4'd0;
        bus.last_addr  = 4'd15;
        bus.dir        = 1'b0;
        bus.start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (29) @(negedge clk);
        tests++;
        if (obs !== 7'b1100111) begin
            fails++;
            $display("FAIL rst_mid_pre got=%b exp=%b", obs, 7'b1100111);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL rst_mid_async got=%b exp=%b", obs, 7'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (obs !== 7'b0) begin
            fails++;
            $display("FAIL rst_mid_after got=%b exp=%b", obs, 7'b0);
        end
        test_sweep(4'd5, 4'd5, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++)
            test_sweep(4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 1'b1, 1'b0);
    endtask

`ifdef SCAN_CONTINUOUS_EN
    task automatic test_repeat();
        logic [6:0] exp;
        bus1.first_addr = 4'd3;
        bus1.last_addr  = 4'd4;
        bus1.dir        = 1'b0;
        bus1.repeat_req = 1'b1;
        bus1.start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp = {2'b11, (i >= 2 && i % 2 == 0),
                   (i % 2 == 1) ? 4'd4 : 4'd3};
            tests++;
            if (obs1 !== exp) begin
                fails++;
                $display("FAIL repeat cyc=%0d got=%b exp=%b", i, obs1, exp);
            end
            if (i == 5) bus1.repeat_req = 1'b0;
            @(negedge clk);
        end
        tests++;
        if (obs1 !== 7'b0010000) begin
            fails++;
            $display("FAIL repeat_done got=%b exp=%b", obs1, 7'b0010000);
        end
        @(negedge clk);
        tests++;
        if (obs1 !== 7'b0) begin
            fails++;
            $display("FAIL repeat_idle got=%b exp=%b", obs1, 7'b0);
        end
    endtask
`endif

    initial begin
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.dir        = 1'b0;
        bus.first_addr = 4'd0;
        bus.last_addr  = 4'd0;
`ifdef SCAN_CONTINUOUS_EN
        bus.repeat_req  = 1'b0;
        bus1.start      = 1'b0;
        bus1.stop       = 1'b0;
        bus1.dir        = 1'b0;
        bus1.first_addr = 4'd0;
        bus1.last_addr  = 4'd0;
        bus1.repeat_req = 1'b0;
`endif
        test_reset();
        test_sweep(4'd0, 4'd15, 1'b0, 1'b0, 1'b0);
        test_sweep(4'd14, 4'd1, 1'b0, 1'b1, 1'b0);
        test_sweep(4'd2, 4'd13, 1'b1, 1'b1, 1'b1);
        test_back_to_back();
        test_stop();
        test_reset_mid();
        test_random();
`ifdef SCAN_CONTINUOUS_EN
        test_repeat();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
